uart_alu_ctrl: RTL and testbench

- Sits between uart_rx and uart_tx, sharing their clock.
- Collects a 3-byte command frame from the receiver (operand A, operand B, opcode) and executes the operation in an internal ALU.
- Hands the 8-bit result to the transmitter and waits for the transmit to complete before accepting the next frame.
- Aborts a partial frame when the gap between bytes exceeds a programmable cycle timeout.

---
 rtl/uart_alu_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl
//   Command front-end between uart_rx and uart_tx. It collects a 3-byte frame
//   (operand A, operand B, opcode), executes the opcode in a small ALU, hands
//   the result to the transmitter and waits for the transmit to complete
//   before it accepts the next frame. A partial frame is dropped when the
//   idle gap between its bytes reaches TIMEOUT_CYCLES.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-low reset
//   i_rx_done   one-cycle pulse from uart_rx, i_rx_data valid in that cycle
//   i_rx_data   received byte
//   i_tx_done   one-cycle pulse from uart_tx at the end of the stop bit
//   o_tx_start  one-cycle pulse that starts transmission of o_tx_data
//   o_tx_data   byte to transmit (the result register)
//   o_result    last computed result, held until the next valid execution
//   o_busy      high from EXEC through WAIT_TX
//   o_error     one-cycle pulse on an unsupported opcode
//   o_timeout   one-cycle pulse when a partial frame is aborted
module uart_alu_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned OP_WIDTH       = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned TO_WIDTH       = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_tx_done,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_busy,
  output logic                  o_error,
  output logic                  o_timeout
);

  typedef enum logic [2:0] {
    S_GET_A,
    S_GET_B,
    S_GET_OP,
    S_EXEC,
    S_SEND,
    S_WAIT_TX
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(6'b100000);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(6'b100010);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(6'b100100);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(6'b100101);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(6'b100110);
  localparam logic [OP_WIDTH-1:0] OP_NOR = OP_WIDTH'(6'b100111);
  localparam logic [OP_WIDTH-1:0] OP_SRA = OP_WIDTH'(6'b000011);
  localparam logic [OP_WIDTH-1:0] OP_SRL = OP_WIDTH'(6'b000010);

  localparam logic [TO_WIDTH-1:0]   TO_LAST     = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] SHIFT_LIMIT = DATA_WIDTH'(DATA_WIDTH);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] a_reg, b_reg, result_reg;
  logic [OP_WIDTH-1:0]   op_reg;
  logic [TO_WIDTH-1:0]   to_cnt;

  logic                  load_a, load_b, load_op, load_result;
  logic                  cnt_clr, cnt_inc;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_valid;

  // Opcode bits above OP_WIDTH carry no meaning.
  logic unused_rx_hi;
  assign unused_rx_hi = ^i_rx_data[DATA_WIDTH-1:OP_WIDTH];

  // ALU: combinational on the latched operands, consumed only in EXEC.
  always_comb begin
    alu_res   = '0;
    alu_valid = 1'b1;
    case (op_reg)
      OP_ADD: alu_res = a_reg + b_reg;
      OP_SUB: alu_res = a_reg - b_reg;
      OP_AND: alu_res = a_reg & b_reg;
      OP_OR:  alu_res = a_reg | b_reg;
      OP_XOR: alu_res = a_reg ^ b_reg;
      OP_NOR: alu_res = ~(a_reg | b_reg);
      OP_SRL: begin
        if (b_reg >= SHIFT_LIMIT) alu_res = '0;
        else                      alu_res = a_reg >> b_reg;
      end
      OP_SRA: begin
        // Oversized shift counts saturate to the sign fill.
        if (b_reg >= SHIFT_LIMIT) alu_res = {DATA_WIDTH{a_reg[DATA_WIDTH-1]}};
        else                      alu_res = $unsigned($signed(a_reg) >>> b_reg);
      end
      default: alu_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_GET_A;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load_a      = 1'b0;
    load_b      = 1'b0;
    load_op     = 1'b0;
    load_result = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    o_tx_start  = 1'b0;
    o_busy      = 1'b0;
    o_error     = 1'b0;
    o_timeout   = 1'b0;
    case (state)
      S_GET_A: begin
        if (i_rx_done) begin
          load_a     = 1'b1;
          cnt_clr    = 1'b1;
          state_next = S_GET_B;
        end
      end
      S_GET_B: begin
        // A byte arriving on the terminal count wins over the timeout.
        if (i_rx_done) begin
          load_b     = 1'b1;
          cnt_clr    = 1'b1;
          state_next = S_GET_OP;
        end else if (to_cnt == TO_LAST) begin
          o_timeout  = 1'b1;
          cnt_clr    = 1'b1;
          state_next = S_GET_A;
        end else begin
          cnt_inc    = 1'b1;
        end
      end
      S_GET_OP: begin
        if (i_rx_done) begin
          load_op    = 1'b1;
          state_next = S_EXEC;
        end else if (to_cnt == TO_LAST) begin
          o_timeout  = 1'b1;
          cnt_clr    = 1'b1;
          state_next = S_GET_A;
        end else begin
          cnt_inc    = 1'b1;
        end
      end
      S_EXEC: begin
        o_busy = 1'b1;
        if (alu_valid) begin
          load_result = 1'b1;
          state_next  = S_SEND;
        end else begin
          o_error    = 1'b1;
          state_next = S_GET_A;
        end
      end
      S_SEND: begin
        o_busy     = 1'b1;
        o_tx_start = 1'b1;
        state_next = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        o_busy = 1'b1;
        if (i_tx_done) state_next = S_GET_A;
      end
      default: state_next = S_GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      to_cnt     <= '0;
    end else begin
      if (load_a)      a_reg      <= i_rx_data;
      if (load_b)      b_reg      <= i_rx_data;
      if (load_op)     op_reg     <= i_rx_data[OP_WIDTH-1:0];
      if (load_result) result_reg <= alu_res;
      if (cnt_clr)      to_cnt <= '0;
      else if (cnt_inc) to_cnt <= to_cnt + TO_WIDTH'(1);
    end
  end

  assign o_tx_data = result_reg;
  assign o_result  = result_reg;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl (TIMEOUT_CYCLES shortened to 50).
module tb_uart_alu_ctrl;

  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = '0;
  logic       tx_done = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] result;
  logic       busy;
  logic       error;
  logic       timeout;

  uart_alu_ctrl #(
    .DATA_WIDTH(8),
    .OP_WIDTH(6),
    .TIMEOUT_CYCLES(TO),
    .TO_WIDTH(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_rx_done(rx_done),
    .i_rx_data(rx_data),
    .i_tx_done(tx_done),
    .o_tx_start(tx_start),
    .o_tx_data(tx_data),
    .o_result(result),
    .o_busy(busy),
    .o_error(error),
    .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int mon_tx = 0, mon_err = 0, mon_to = 0;
  int exp_tx = 0, exp_err = 0, exp_to = 0;
  logic [7:0] exp_result = '0;

  // Pulse counters, sampled half a cycle away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      if (tx_start) mon_tx++;
      if (error)    mon_err++;
      if (timeout)  mon_to++;
    end
  end

  initial begin
    #400_000;
    $display("FAIL watchdog: got no finish, required finish before 400000 ns");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic       err;
    logic [7:0] res;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  // Reference ALU: plain integer arithmetic on the opcode semantics.
  function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    int ia, ib, sa, q, p;
    logic [7:0] r;
    logic v;
    ia = int'(a);
    ib = int'(b);
    v  = 1'b1;
    r  = '0;
    case (op)
      6'h20: r = 8'((ia + ib) % 256);
      6'h22: r = 8'((ia - ib + 256) % 256);
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h02: r = (ib >= 8) ? 8'h00 : 8'(ia / (1 << ib));
      6'h03: begin
        sa = (ia >= 128) ? ia - 256 : ia;
        if (ib >= 8) r = (ia >= 128) ? 8'hFF : 8'h00;
        else begin
          p = 1 << ib;
          q = sa / p;
          if (sa < 0 && (sa % p) != 0) q = q - 1;  // floor division
          r = 8'(q);
        end
      end
      default: v = 1'b0;
    endcase
    return {v, r};
  endfunction

  // Called at #1 after the edge that took the opcode byte (DUT in EXEC).
  task automatic check_exec(input logic err, input logic [7:0] res, input logic inject);
    check("exec_busy", busy, 1);
    check("exec_tx_start", tx_start, 0);
    check("exec_error", error, err);
    check("exec_result_hold", result, exp_result);
    tick();
    if (err) begin
      exp_err++;
      check("err_busy", busy, 0);
      check("err_no_tx", tx_start, 0);
      check("err_result_kept", result, exp_result);
    end else begin
      exp_tx++;
      exp_result = res;
      check("send_tx_start", tx_start, 1);
      check("send_tx_data", tx_data, res);
      check("send_result", result, res);
      check("send_busy", busy, 1);
      tick();
      check("wait_tx_start_low", tx_start, 0);
      idle(int'($urandom_range(0, 4)));
      if (inject) send_byte(8'hAA);
      check("wait_busy", busy, 1);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("done_busy", busy, 0);
      check("done_tx_data_held", tx_data, res);
    end
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic err, input logic [7:0] res, input logic inject);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    check_exec(err, res, inject);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    check("rst_tx_start", tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_timeout", timeout, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_result", result, 0);
    reset = 1'b1;
    exp_result = '0;
  endtask

  vec_t vecs[14];
  logic [7:0] q[$];
  logic [7:0] valid_ops[8];

  initial begin
    vecs[0]  = '{8'h05, 8'h03, 8'h20, 1'b0, 8'h08};  // ADD
    vecs[1]  = '{8'h03, 8'h05, 8'h22, 1'b0, 8'hFE};  // SUB wraps
    vecs[2]  = '{8'h80, 8'h02, 8'h03, 1'b0, 8'hE0};  // SRA
    vecs[3]  = '{8'h80, 8'h09, 8'h02, 1'b0, 8'h00};  // SRL B>=8
    vecs[4]  = '{8'h12, 8'h34, 8'h3F, 1'b1, 8'h00};  // invalid
    vecs[5]  = '{8'h0F, 8'hF0, 8'h25, 1'b0, 8'hFF};  // OR
    vecs[6]  = '{8'hF0, 8'h3C, 8'h24, 1'b0, 8'h30};  // AND
    vecs[7]  = '{8'hF0, 8'h3C, 8'h26, 1'b0, 8'hCC};  // XOR
    vecs[8]  = '{8'hF0, 8'h0C, 8'h27, 1'b0, 8'h03};  // NOR
    vecs[9]  = '{8'hF0, 8'h04, 8'h02, 1'b0, 8'h0F};  // SRL
    vecs[10] = '{8'h80, 8'h0A, 8'h03, 1'b0, 8'hFF};  // SRA B>=8 negative
    vecs[11] = '{8'h7F, 8'h08, 8'h03, 1'b0, 8'h00};  // SRA B==8 positive
    vecs[12] = '{8'h10, 8'h20, 8'hE0, 1'b0, 8'h30};  // upper opcode bits ignored
    vecs[13] = '{8'h55, 8'hAA, 8'h21, 1'b1, 8'h00};  // invalid
    valid_ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};

    reset = 1'b0;
    tick();
    do_reset();

    for (int i = 0; i < 14; i++)
      run_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].err, vecs[i].res, 1'b0);

    // Byte during WAIT_TX is dropped; next frame starts cleanly.
    run_frame(8'h01, 8'h01, 8'h20, 1'b0, 8'h02, 1'b1);
    run_frame(8'hFF, 8'h01, 8'h20, 1'b0, 8'h00, 1'b0);

    // Timeout after A only: pulse exactly on the 50th idle cycle.
    send_byte(8'h33);
    check("to_pulse_early", timeout, 0);
    for (int i = 1; i < TO; i++) begin
      tick();
      check("to_pulse", timeout, (i == TO - 1) ? 1 : 0);
    end
    exp_to++;
    tick();
    check("to_pulse_after", timeout, 0);
    check("to_busy", busy, 0);
    run_frame(8'h0F, 8'hF0, 8'h25, 1'b0, 8'hFF, 1'b0);

    // Byte coinciding with terminal count wins (gap of 49 idle cycles).
    send_byte(8'h05);
    idle(TO - 1);
    send_byte(8'h06);
    idle(TO - 1);
    send_byte(8'h20);
    check_exec(1'b0, 8'h0B, 1'b0);

    // Timeout while waiting for the opcode.
    send_byte(8'h44);
    send_byte(8'h11);
    idle(TO);
    exp_to++;
    run_frame(8'h09, 8'h02, 8'h22, 1'b0, 8'h07, 1'b0);

    // Reset during WAIT_TX.
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    tick();
    exp_tx++;
    tick();
    check("pre_rst_busy", busy, 1);
    do_reset();
    run_frame(8'h09, 8'h01, 8'h22, 1'b0, 8'h08, 1'b0);

    // Reset after only A was received.
    send_byte(8'h77);
    do_reset();
    run_frame(8'h01, 8'h02, 8'h20, 1'b0, 8'h03, 1'b0);

    // Random byte stream against the frame/timeout model.
    q.delete();
    for (int k = 0; k < 150; k++) begin
      int gap;
      logic [7:0] bv;
      logic [8:0] r;
      gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(48, 52)) : int'($urandom_range(0, 3));
      idle(gap);
      if (q.size() > 0 && gap >= TO) begin
        exp_to++;
        q.delete();
      end
      if (q.size() == 2) begin
        bv = ($urandom_range(0, 3) != 0) ? valid_ops[$urandom_range(0, 7)] : 8'($urandom_range(0, 63));
        bv[7:6] = 2'($urandom_range(0, 3));
      end else if (q.size() == 1 && $urandom_range(0, 1) == 1) begin
        bv = 8'($urandom_range(0, 10));
      end else begin
        bv = 8'($urandom_range(0, 255));
      end
      send_byte(bv);
      q.push_back(bv);
      if (q.size() == 3) begin
        r = ref_alu(q[0], q[1], q[2][5:0]);
        check_exec(~r[8], r[7:0], ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        q.delete();
      end
    end

    tick();
    check("count_tx_start", mon_tx, exp_tx);
    check("count_error", mon_err, exp_err);
    check("count_timeout", mon_to, exp_to);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
